// File: rtl/operand_fwd_ctrl_pkg.sv
// fwd_pkg: shared definitions for the EX-stage operand forwarding controller.
//   - FWD_REG_AW / FWD_SEL_W : default register-index and mux-select widths
//   - sel_e                  : operand mux select encoding (5 sources)
//   - trk_t                  : in-flight tracker entry {valid, rd, wr} (MEM stage)
//   - trk_ld_t               : tracker entry plus load flag (EX stage)
//   - is_producer / is_fwd   : helpers shared by the controller and its sub-module
`timescale 1ns/1ps
package fwd_pkg;

  localparam int unsigned FWD_REG_AW = 4;
  localparam int unsigned FWD_SEL_W  = 3;

  typedef enum logic [FWD_SEL_W-1:0] {
    SEL_RF    = 3'b000,
    SEL_EXMEM = 3'b001,
    SEL_ZERO  = 3'b010,
    SEL_MEMWB = 3'b011,
    SEL_IMM   = 3'b100
  } sel_e;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  wr;
  } trk_t;

  typedef struct packed {
    trk_t ent;
    logic load;
  } trk_ld_t;

  // r0 is hardwired zero, so a write to it never produces a forwardable value.
  function automatic logic is_producer(input trk_t e);
    return e.valid & e.wr & (e.rd != '0);
  endfunction

  function automatic logic is_fwd(input sel_e s);
    return (s == SEL_EXMEM) || (s == SEL_MEMWB);
  endfunction

endpackage

// File: rtl/operand_fwd_ctrl_if.sv
// operand_fwd_ctrl_if: ID-stage request / EX-stage select bundle.
//   master : pipeline side, drives id_* and flush, observes stall and ex_*
//   slave  : forwarding controller side
//   id_valid, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load, id_use_imm, flush
//   stall (combinational), ex_valid, ex_sel_a, ex_sel_b (registered)
// Optional (OPERAND_FWD_STATS_EN): stall_cnt[15:0], fwd_cnt[15:0].
`timescale 1ns/1ps
interface operand_fwd_ctrl_if #(
  parameter int unsigned REG_AW = fwd_pkg::FWD_REG_AW,
  parameter int unsigned SEL_W  = fwd_pkg::FWD_SEL_W
) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_is_load;
  logic              id_use_imm;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [SEL_W-1:0]  ex_sel_a;
  logic [SEL_W-1:0]  ex_sel_b;
`ifdef OPERAND_FWD_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       fwd_cnt;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load, id_use_imm, flush,
`ifdef OPERAND_FWD_STATS_EN
    input  stall_cnt, fwd_cnt,
`endif
    input  stall, ex_valid, ex_sel_a, ex_sel_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load, id_use_imm, flush,
`ifdef OPERAND_FWD_STATS_EN
    output stall_cnt, fwd_cnt,
`endif
    output stall, ex_valid, ex_sel_a, ex_sel_b
  );

endinterface

// File: rtl/operand_fwd_ctrl_src_sel.sv
// fwd_src_sel: combinational source-vs-tracker compare for one operand.
//   rs       : ID-stage source register index
//   p1, p2   : tracker entries for the instructions in EX and MEM
//   sel      : mux select (RF / EXMEM / ZERO / MEMWB); immediate handled by parent
//   load_hit : rs (non-zero) matches a load producer in EX -> load-use hazard
`timescale 1ns/1ps
module fwd_src_sel
  import fwd_pkg::*;
(
  input  logic [FWD_REG_AW-1:0] rs,
  input  trk_ld_t               p1,
  input  trk_t                  p2,
  output sel_e                  sel,
  output logic                  load_hit
);

  logic p1_match;
  logic p2_match;

  always_comb begin
    p1_match = is_producer(p1.ent) && (p1.ent.rd == rs);
    p2_match = is_producer(p2) && (p2.rd == rs);
    load_hit = p1_match && p1.load && (rs != '0);

    // Newest producer wins; a load in EX cannot forward yet, so it falls
    // through (the parent stalls in that case).
    sel = SEL_RF;
    if (rs == '0)
      sel = SEL_ZERO;
    else if (p1_match && !p1.load)
      sel = SEL_EXMEM;
    else if (p2_match)
      sel = SEL_MEMWB;
  end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: forwarding and load-use hazard controller for the EX-stage
// 16-bit five-input operand mux.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand_fwd_ctrl_if.slave (ID request in, stall and EX selects out)
// Tracks the two older in-flight instructions (P1 = EX, P2 = MEM), compares
// them with the ID sources and registers the mux selects for EX (latency 1).
// A load in EX feeding an ID source stalls for one cycle and injects a bubble.
// Optional build macro OPERAND_FWD_STATS_EN adds saturating stall/forward
// counters on the interface. REG_AW / SEL_W must match the fwd_pkg widths.
`timescale 1ns/1ps
module operand_fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = FWD_REG_AW,
  parameter int unsigned SEL_W  = FWD_SEL_W
) (
  input logic               clk,
  input logic               rst_n,
  operand_fwd_ctrl_if.slave bus
);

  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  trk_ld_t           p1;
  trk_t              p2;
  sel_e              sel_a;
  sel_e              sel_b_raw;
  sel_e              sel_b;
  logic              hit_a;
  logic              hit_b;
  logic              stall_c;
  logic              kill;

  logic              ex_valid_q;
  logic [SEL_W-1:0]  sel_a_q;
  logic [SEL_W-1:0]  sel_b_q;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;

  fwd_src_sel u_sel_a (
    .rs       (rs1),
    .p1       (p1),
    .p2       (p2),
    .sel      (sel_a),
    .load_hit (hit_a)
  );

  fwd_src_sel u_sel_b (
    .rs       (rs2),
    .p1       (p1),
    .p2       (p2),
    .sel      (sel_b_raw),
    .load_hit (hit_b)
  );

  // Reset clears P1.valid, which alone forces stall low while rst_n is held.
  always_comb begin
    sel_b   = bus.id_use_imm ? SEL_IMM : sel_b_raw;
    stall_c = bus.id_valid & ~bus.flush & (hit_a | (hit_b & ~bus.id_use_imm));
    kill    = bus.flush | stall_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1         <= '0;
      p2         <= '0;
      ex_valid_q <= 1'b0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
    end else begin
      p2 <= p1.ent;
      if (kill) begin
        p1         <= '0;
        ex_valid_q <= 1'b0;
        sel_a_q    <= '0;
        sel_b_q    <= '0;
      end else begin
        p1.ent.valid <= bus.id_valid;
        p1.ent.rd    <= bus.id_rd;
        p1.ent.wr    <= bus.id_wr_en;
        p1.load      <= bus.id_is_load;
        ex_valid_q   <= bus.id_valid;
        sel_a_q      <= sel_a;
        sel_b_q      <= sel_b;
      end
    end
  end

  assign bus.stall    = stall_c;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_sel_a = sel_a_q;
  assign bus.ex_sel_b = sel_b_q;

`ifdef OPERAND_FWD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] fwd_cnt_q;
  logic        fwd_load;

  // One count per cycle, however many operands forward.
  assign fwd_load = ~kill & (is_fwd(sel_a) | is_fwd(sel_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (fwd_load && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// tb_operand_fwd_ctrl: directed self-checking bench for operand_fwd_ctrl.
// Each issue() applies one ID-stage instruction, checks stall before the edge
// and the registered EX outputs after it. Build with OPERAND_FWD_STATS_EN to
// also check the counters.
`timescale 1ns/1ps
module tb_operand_fwd_ctrl;
  import fwd_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   exp_stall_n;
  int   exp_fwd_n;

  operand_fwd_ctrl_if bus ();

  operand_fwd_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic fwd_code(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b011);
  endfunction

  // Entered and left at posedge+1.
  task automatic issue(input string tag,
                       input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic wr, input logic ld,
                       input logic imm, input logic fl,
                       input logic e_stall, input logic e_valid,
                       input logic [2:0] e_a, input logic [2:0] e_b);
    bus.id_valid   = v;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_rd      = rd;
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.id_use_imm = imm;
    bus.flush      = fl;
    #1;
    check_eq({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
    if (e_stall) exp_stall_n++;
    if (fwd_code(e_a) || fwd_code(e_b)) exp_fwd_n++;
    @(posedge clk);
    #1;
    check_eq({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(e_valid));
    check_eq({tag, ".ex_sel_a"}, 32'(bus.ex_sel_a), 32'(e_a));
    check_eq({tag, ".ex_sel_b"}, 32'(bus.ex_sel_b), 32'(e_b));
  endtask

  task automatic nop2();
    issue("nop", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_ZERO, SEL_ZERO);
    issue("nop", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_ZERO, SEL_ZERO);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_stall_n = 0;
    exp_fwd_n = 0;
    rst_n = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_rs1 = '0;
    bus.id_rs2 = '0;
    bus.id_rd = '0;
    bus.id_wr_en = 1'b0;
    bus.id_is_load = 1'b0;
    bus.id_use_imm = 1'b0;
    bus.flush = 1'b0;
    #12;
    check_eq("rst.ex_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("rst.ex_sel_a", 32'(bus.ex_sel_a), 32'd0);
    check_eq("rst.ex_sel_b", 32'(bus.ex_sel_b), 32'd0);
    check_eq("rst.stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // EX/MEM forward of the immediately preceding producer
    issue("i0_rd3", 1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 0, 0, 1, SEL_RF, SEL_RF);
    issue("i1_rs1_3", 1, 4'd3, 4'd0, 4'd8, 1, 0, 0, 0, 0, 1, SEL_EXMEM, SEL_ZERO);
    nop2();

    // MEM/WB forward two instructions back; immediate override
    issue("i0_rd5", 1, 4'd0, 4'd0, 4'd5, 1, 0, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("i1_rd6", 1, 4'd1, 4'd2, 4'd6, 1, 0, 0, 0, 0, 1, SEL_RF, SEL_RF);
    issue("i2_rs2_5", 1, 4'd6, 4'd5, 4'd0, 0, 0, 0, 0, 0, 1, SEL_EXMEM, SEL_MEMWB);
    nop2();
    issue("j0_rd5", 1, 4'd0, 4'd0, 4'd5, 1, 0, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("j1_indep", 1, 4'd1, 4'd2, 4'd0, 1, 0, 0, 0, 0, 1, SEL_RF, SEL_RF);
    issue("j2_imm", 1, 4'd2, 4'd5, 4'd0, 0, 0, 1, 0, 0, 1, SEL_RF, SEL_IMM);
    nop2();

    // Both stages match: newest wins; r0 and wr=0 producers never match
    issue("k0_rd7", 1, 4'd0, 4'd0, 4'd7, 1, 0, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("k1_rd7", 1, 4'd0, 4'd0, 4'd7, 1, 0, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("k2_rs1_7", 1, 4'd7, 4'd1, 4'd0, 1, 0, 0, 0, 0, 1, SEL_EXMEM, SEL_RF);
    issue("k3_rs1_0", 1, 4'd0, 4'd7, 4'd0, 0, 0, 0, 0, 0, 1, SEL_ZERO, SEL_MEMWB);
    issue("k4_wr0", 1, 4'd0, 4'd0, 4'd9, 0, 0, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("k5_rs1_9", 1, 4'd9, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, SEL_RF, SEL_ZERO);
    nop2();

    // Load-use on rs1: one stall cycle, then MEM/WB forward
    issue("ld4", 1, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("use4_stall", 1, 4'd4, 4'd0, 4'd10, 1, 0, 0, 0, 1, 0, SEL_RF, SEL_RF);
    issue("use4_retry", 1, 4'd4, 4'd0, 4'd10, 1, 0, 0, 0, 0, 1, SEL_MEMWB, SEL_ZERO);
    nop2();
    // rs2 matches the load but operand B is the immediate: no hazard
    issue("ld4b", 1, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("use4_imm", 1, 4'd1, 4'd4, 4'd0, 0, 0, 1, 0, 0, 1, SEL_RF, SEL_IMM);
    nop2();
    // Load-use on rs2
    issue("ld4c", 1, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("use4_rs2", 1, 4'd0, 4'd4, 4'd0, 0, 0, 0, 0, 1, 0, SEL_RF, SEL_RF);
    issue("use4_rs2_retry", 1, 4'd0, 4'd4, 4'd0, 0, 0, 0, 0, 0, 1, SEL_ZERO, SEL_MEMWB);
    nop2();
    // Load to r0 never stalls
    issue("ld_r0", 1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("use_r0", 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    nop2();

    // Flush in the hazard cycle beats the stall
    issue("ld4d", 1, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    issue("use4_flush", 1, 4'd4, 4'd0, 4'd0, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF);
`ifdef OPERAND_FWD_STATS_EN
    check_eq("stats.stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall_n));
    check_eq("stats.fwd_cnt", 32'(bus.fwd_cnt), 32'(exp_fwd_n));
`endif
    nop2();

    // Asynchronous reset mid-stream with a pending load-use hazard
    issue("ld4e", 1, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, 1, SEL_ZERO, SEL_ZERO);
    bus.id_valid = 1'b1;
    bus.id_rs1 = 4'd4;
    bus.id_rs2 = 4'd0;
    bus.id_rd = 4'd0;
    bus.id_wr_en = 1'b0;
    bus.id_is_load = 1'b0;
    bus.id_use_imm = 1'b0;
    bus.flush = 1'b0;
    #1;
    check_eq("pre_rst.stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst.stall", 32'(bus.stall), 32'd0);
    check_eq("mid_rst.ex_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("mid_rst.ex_sel_a", 32'(bus.ex_sel_a), 32'd0);
    check_eq("mid_rst.ex_sel_b", 32'(bus.ex_sel_b), 32'd0);
    exp_stall_n = 0;
    exp_fwd_n = 0;
`ifdef OPERAND_FWD_STATS_EN
    check_eq("mid_rst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check_eq("mid_rst.fwd_cnt", 32'(bus.fwd_cnt), 32'd0);
`endif
    @(posedge clk);
    #2;
    bus.id_valid = 1'b0;
    bus.id_rs1 = 4'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("post_rst", 1, 4'd3, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, SEL_RF, SEL_ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
